nrzi_decode: RTL and testbench

Receive-side NRZI decoder and USB 2.0 packet-field tracker. It converts the single-wire NRZI line into decoded bits, removes stuffed bits, and computes the next one-hot packet-field state from the current state and the decoded bit stream. It sits between the line, driven in the codebase by the NRZI encoder's `tx_data_out`, and the receive packet logic. That logic registers the `*_n` next-state outputs and feeds them back as the current-state inputs.

---
 rtl/nrzi_decode.sv | 155 +++++++++++++++
 tb/tb_nrzi_decode.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_decode.sv
`default_nettype none
// ============================================================================
// Module   : nrzi_decode
// Purpose  : NRZI line decoder with bit-unstuffing and USB packet-field next-state logic.
// Revision : 1.0
// ============================================================================
module nrzi_decode (
  input  logic gclk,
  input  logic reset_l,
  input  logic start_rxd,
  input  logic tx_data_out,
  input  logic idle_or_sync,
  input  logic pid,
  input  logic dev_address,
  input  logic end_point_address,
  input  logic crc5,
  input  logic frame_number,
  input  logic data_crc_eop,
  input  logic eop,
  input  logic error,
  output logic rx_data_out,
  output logic rx_data_valid,
  output logic idle_or_sync_n,
  output logic pid_n,
  output logic dev_address_n,
  output logic end_point_address_n,
  output logic crc5_n,
  output logic frame_number_n,
  output logic data_crc_eop_n,
  output logic eop_n,
  output logic error_n
);

  localparam logic [8:0] ST_IDLE  = 9'b0_0000_0001;
  localparam logic [8:0] ST_PID   = 9'b0_0000_0010;
  localparam logic [8:0] ST_DEV   = 9'b0_0000_0100;
  localparam logic [8:0] ST_EP    = 9'b0_0000_1000;
  localparam logic [8:0] ST_CRC5  = 9'b0_0001_0000;
  localparam logic [8:0] ST_FRAME = 9'b0_0010_0000;
  localparam logic [8:0] ST_DATA  = 9'b0_0100_0000;
  localparam logic [8:0] ST_EOP   = 9'b0_1000_0000;
  localparam logic [8:0] ST_ERROR = 9'b1_0000_0000;

  localparam logic [3:0] PID_LAST   = 4'd7;
  localparam logic [3:0] DEV_LAST   = 4'd6;
  localparam logic [3:0] EP_LAST    = 4'd3;
  localparam logic [3:0] FRAME_LAST = 4'd10;
  localparam logic [3:0] CRC5_LAST  = 4'd4;

  logic       prev_line;
  logic       en_q;
  logic       prev_six;
  logic [2:0] ones_cnt;
  logic [7:0] zero_sr;
  logic [3:0] field_cnt;
  logic [6:0] pid_sr;

  logic       line_bit;
  logic       stuff_field;
  logic       stuffed;
  logic       violation;
  logic       seven_ones;
  logic       sync_seen;
  logic       pid_ok;
  logic [7:0] pid_full;
  logic [8:0] pid_target;
  logic [8:0] state_vec;
  logic [8:0] next_vec;

  assign line_bit  = (tx_data_out == prev_line);
  assign state_vec = {error, eop, data_crc_eop, frame_number, crc5,
                      end_point_address, dev_address, pid, idle_or_sync};

  assign stuff_field = pid | dev_address | end_point_address | crc5 |
                       frame_number | data_crc_eop;
  // prev_six: the bit now on rx_data_out follows exactly six consecutive 1s
  assign stuffed       = en_q & stuff_field & prev_six;
  assign rx_data_valid = en_q & ~(stuffed & ~rx_data_out);
  assign violation     = stuffed & rx_data_out;
  assign seven_ones    = prev_six & rx_data_out;
  assign sync_seen     = rx_data_out & (&zero_sr[7:1]);
  assign pid_full      = {rx_data_out, pid_sr};
  assign pid_ok        = (pid_full[7:4] == ~pid_full[3:0]);

  always_comb begin
    case (pid_full[3:0])
      4'b0001, 4'b1001, 4'b1101: pid_target = ST_DEV;
      4'b0101:                   pid_target = ST_FRAME;
      4'b0011, 4'b1011:          pid_target = ST_DATA;
      4'b0010, 4'b1010, 4'b1110: pid_target = ST_EOP;
      default:                   pid_target = ST_ERROR;
    endcase
  end

  always_comb begin
    next_vec = state_vec;
    if (reset_l || !start_rxd) begin
      next_vec = ST_IDLE;
    end else if (!$onehot(state_vec)) begin
      next_vec = ST_ERROR;
    end else if (rx_data_valid) begin
      if (violation) begin
        next_vec = data_crc_eop ? ST_IDLE : ST_ERROR;
      end else if (idle_or_sync) begin
        if (sync_seen) next_vec = ST_PID;
      end else if (pid) begin
        if (field_cnt == PID_LAST) next_vec = pid_ok ? pid_target : ST_ERROR;
      end else if (dev_address) begin
        if (field_cnt == DEV_LAST) next_vec = ST_EP;
      end else if (end_point_address) begin
        if (field_cnt == EP_LAST) next_vec = ST_CRC5;
      end else if (frame_number) begin
        if (field_cnt == FRAME_LAST) next_vec = ST_CRC5;
      end else if (crc5) begin
        if (field_cnt == CRC5_LAST) next_vec = ST_EOP;
      end else if (eop) begin
        if (!rx_data_out) next_vec = ST_ERROR;
        else if (seven_ones) next_vec = ST_IDLE;
      end else if (error) begin
        if (seven_ones) next_vec = ST_IDLE;
      end
    end
  end

  assign {error_n, eop_n, data_crc_eop_n, frame_number_n, crc5_n,
          end_point_address_n, dev_address_n, pid_n, idle_or_sync_n} = next_vec;

  always_ff @(posedge gclk) begin
    if (reset_l) begin
      prev_line   <= 1'b1;
      rx_data_out <= 1'b0;
      en_q        <= 1'b0;
      prev_six    <= 1'b0;
      ones_cnt    <= 3'd0;
      zero_sr     <= 8'd0;
      field_cnt   <= 4'd0;
      pid_sr      <= 7'd0;
    end else begin
      en_q <= start_rxd;
      if (start_rxd) begin
        rx_data_out <= line_bit;
        prev_line   <= tx_data_out;
        prev_six    <= (ones_cnt == 3'd6);
        zero_sr     <= {zero_sr[6:0], ~line_bit};
        if (!line_bit)              ones_cnt <= 3'd0;
        else if (ones_cnt != 3'd7)  ones_cnt <= ones_cnt + 3'd1;
      end
      if (next_vec != state_vec)  field_cnt <= 4'd0;
      else if (rx_data_valid)     field_cnt <= field_cnt + 4'd1;
      if (pid && rx_data_valid)   pid_sr <= {rx_data_out, pid_sr[6:1]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrzi_decode.sv
`default_nettype none
// Bench for nrzi_decode: directed line patterns, a run-length packet model checked
// every cycle, plus literal expectations at key packet points.
module tb_nrzi_decode;

  localparam int S_IDLE = 0, S_PID = 1, S_DEV = 2, S_EP = 3, S_CRC = 4,
                 S_FRAME = 5, S_DATA = 6, S_EOP = 7, S_ERR = 8;
  localparam logic [8:0] STUFF_MASK = 9'b0_0111_1110;

  logic gclk = 1'b0;
  logic reset_l = 1'b1, start_rxd = 1'b0, tx_data_out = 1'b1;
  logic [8:0] state_q = 9'b1;
  logic force_en = 1'b0;
  logic [8:0] force_val = 9'b1;
  logic rx_data_out, rx_data_valid;
  logic idle_or_sync_n, pid_n, dev_address_n, end_point_address_n, crc5_n;
  logic frame_number_n, data_crc_eop_n, eop_n, error_n;
  logic [8:0] dut_next;

  int checks = 0;
  int errors = 0;
  logic cur_line = 1'b1;

  always #5 gclk = ~gclk;

  nrzi_decode dut (
    .gclk(gclk), .reset_l(reset_l), .start_rxd(start_rxd), .tx_data_out(tx_data_out),
    .idle_or_sync(state_q[0]), .pid(state_q[1]), .dev_address(state_q[2]),
    .end_point_address(state_q[3]), .crc5(state_q[4]), .frame_number(state_q[5]),
    .data_crc_eop(state_q[6]), .eop(state_q[7]), .error(state_q[8]),
    .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
    .idle_or_sync_n(idle_or_sync_n), .pid_n(pid_n), .dev_address_n(dev_address_n),
    .end_point_address_n(end_point_address_n), .crc5_n(crc5_n),
    .frame_number_n(frame_number_n), .data_crc_eop_n(data_crc_eop_n),
    .eop_n(eop_n), .error_n(error_n)
  );

  assign dut_next = {error_n, eop_n, data_crc_eop_n, frame_number_n, crc5_n,
                     end_point_address_n, dev_address_n, pid_n, idle_or_sync_n};

  // Stand-in for the downstream packet logic that registers the next state.
  always @(posedge gclk) state_q <= force_en ? force_val : dut_next;

  // ---------------- reference model ----------------
  logic [8:0] m_state = 9'b1, m_next = 9'b1;
  logic m_rx = 1'b0, m_valid = 1'b0, m_en = 1'b0, m_prev = 1'b1, m_live = 1'b0;
  int m_ones = 0, m_zeros = 0, m_ones_before = 0, m_zeros_before = 0;
  int m_fcnt = 0, m_pidv = 0;

  function automatic int idx_of(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return S_ERR;
  endfunction

  function automatic int pid_dest(input int p);
    int lo, hi;
    lo = p & 15;
    hi = (p >> 4) & 15;
    if (hi != (~lo & 15)) return S_ERR;
    case (lo)
      1, 9, 13:  return S_DEV;
      5:         return S_FRAME;
      3, 11:     return S_DATA;
      2, 10, 14: return S_EOP;
      default:   return S_ERR;
    endcase
  endfunction

  function automatic int field_len(input int s);
    case (s)
      S_DEV:   return 7;
      S_EP:    return 4;
      S_FRAME: return 11;
      S_CRC:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int field_after(input int s);
    case (s)
      S_DEV:          return S_EP;
      S_EP, S_FRAME:  return S_CRC;
      default:        return S_EOP;
    endcase
  endfunction

  initial begin
    int cur, nidx;
    logic stuff, viol, sev;
    forever begin
      @(posedge gclk);
      m_state = force_en ? force_val : m_next;
      if (reset_l) begin
        m_rx = 1'b0; m_prev = 1'b1; m_en = 1'b0;
        m_ones = 0; m_zeros = 0; m_ones_before = 0; m_zeros_before = 0; m_fcnt = 0;
      end else begin
        m_en = start_rxd;
        if (start_rxd) begin
          m_rx = (tx_data_out == m_prev);
          m_prev = tx_data_out;
          m_ones_before = m_ones;
          m_zeros_before = m_zeros;
          if (m_rx) begin m_ones++; m_zeros = 0; end
          else begin m_zeros++; m_ones = 0; end
        end
      end
      stuff   = (m_state & STUFF_MASK) != 9'd0;
      m_valid = m_en && !(stuff && m_ones_before == 6 && !m_rx);
      viol    = m_en && stuff && m_ones_before == 6 && m_rx;
      sev     = (m_ones_before == 6) && m_rx;
      if (reset_l || !start_rxd) m_next = 9'b1;
      else if ($countones(m_state) != 1) m_next = 9'b1 << S_ERR;
      else if (!m_valid) m_next = m_state;
      else begin
        cur = idx_of(m_state);
        nidx = cur;
        if (viol) nidx = (cur == S_DATA) ? S_IDLE : S_ERR;
        else case (cur)
          S_IDLE: if (m_zeros_before >= 7 && m_rx) nidx = S_PID;
          S_PID: begin
            if (m_fcnt == 0) m_pidv = 0;
            m_pidv = m_pidv | (int'(m_rx) << m_fcnt);
            if (m_fcnt == 7) nidx = pid_dest(m_pidv);
          end
          S_DEV, S_EP, S_CRC, S_FRAME:
            if (m_fcnt == field_len(cur) - 1) nidx = field_after(cur);
          S_EOP: if (!m_rx) nidx = S_ERR; else if (sev) nidx = S_IDLE;
          S_ERR: if (sev) nidx = S_IDLE;
          default: nidx = cur;
        endcase
        m_next = 9'b1 << nidx;
      end
      if (m_next != m_state) m_fcnt = 0;
      else if (m_valid) m_fcnt++;
      m_live = 1'b1;
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge gclk);
      if (m_live) begin
        check("model rx_data_out", {8'd0, rx_data_out}, {8'd0, m_rx});
        check("model rx_data_valid", {8'd0, rx_data_valid}, {8'd0, m_valid});
        check("model next_state", dut_next, m_next);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic s, input logic l);
    reset_l = r; start_rxd = s; tx_data_out = l;
    @(negedge gclk);
    #1;
  endtask

  task automatic do_reset();
    cur_line = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur_line = ~cur_line;
    step(1'b0, 1'b1, cur_line);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  initial begin
    logic [3:0] line_pat;
    // reset
    do_reset();
    check("reset rx_data_out", {8'd0, rx_data_out}, 9'd0);
    check("reset rx_data_valid", {8'd0, rx_data_valid}, 9'd0);
    check("reset next", dut_next, 9'h001);

    // decode: line high five cycles, then toggling
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check("decode steady", {8'd0, rx_data_out}, 9'd1);
    end
    line_pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, line_pat[i]);
      check("decode toggle", {8'd0, rx_data_out}, 9'd0);
    end
    step(1'b0, 1'b0, 1'b1);
    check("start low valid", {8'd0, rx_data_valid}, 9'd0);
    check("start low hold", {8'd0, rx_data_out}, 9'd0);

    // SOF packet
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h00A5, 8);
    check("sof pid->frame", {8'd0, frame_number_n}, 9'd1);
    send_bits(16'h0123, 11);
    check("frame->crc5", {8'd0, crc5_n}, 9'd1);
    send_bits(16'h000A, 5);
    check("crc5->eop", {8'd0, eop_n}, 9'd1);
    send_ones(6);
    check("eop six ones", {8'd0, eop_n}, 9'd1);
    send_bit(1'b1);
    check("eop->idle", {8'd0, idle_or_sync_n}, 9'd1);

    // IN token, address 0x7F with a stuffed zero
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h0069, 8);
    check("in pid->dev", {8'd0, dev_address_n}, 9'd1);
    send_ones(6);
    send_bit(1'b0);
    check("stuffed valid", {8'd0, rx_data_valid}, 9'd0);
    check("stuffed holds dev", {8'd0, dev_address_n}, 9'd1);
    send_bit(1'b1);
    check("dev->ep", {8'd0, end_point_address_n}, 9'd1);
    send_bits(16'h0000, 4);
    check("ep->crc5", {8'd0, crc5_n}, 9'd1);
    send_bits(16'h000A, 5);
    send_ones(7);
    check("in eop->idle", {8'd0, idle_or_sync_n}, 9'd1);

    // last address bit is also a stuff violation
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h0069, 8);
    send_ones(7);
    check("violation wins", dut_next, 9'h100);
    send_bit(1'b0);
    send_ones(7);
    check("error->idle", {8'd0, idle_or_sync_n}, 9'd1);

    // DATA0 with a stuffed zero, ended by a stuff violation
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h00C3, 8);
    check("data pid", {8'd0, data_crc_eop_n}, 9'd1);
    send_bit(1'b0);
    send_ones(6);
    send_bit(1'b0);
    check("data stuffed valid", {8'd0, rx_data_valid}, 9'd0);
    send_ones(6);
    send_bit(1'b1);
    check("data violation->idle", dut_next, 9'h001);

    // bad PID, then constant line
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h0000, 8);
    check("bad pid", dut_next, 9'h100);
    send_ones(6);
    check("error holds", {8'd0, error_n}, 9'd1);
    send_bit(1'b1);
    check("bad pid recover", {8'd0, idle_or_sync_n}, 9'd1);
    send_bit(1'b1);

    // reset during frame_number
    do_reset();
    send_bits(16'h0080, 8);
    send_bits(16'h00A5, 8);
    send_bits(16'h0005, 3);
    cur_line = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("mid reset idle", dut_next, 9'h001);
    send_bits(16'h0080, 8);
    send_bits(16'h00A5, 8);
    check("after reset sof", {8'd0, frame_number_n}, 9'd1);

    // illegal current state
    force_val = 9'b0_0001_0010;
    force_en = 1'b1;
    send_bit(1'b0);
    force_en = 1'b0;
    check("illegal state", dut_next, 9'h100);
    send_bit(1'b0);
    send_ones(7);
    check("illegal recover", {8'd0, idle_or_sync_n}, 9'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
